gshare_bht: RTL and testbench
=============================

Name: gshare_bht

Overview:
- Next-generation conditional-branch direction predictor for the CVA6 frontend; successor to the bimodal BHT.
- Pattern table of N-bit saturating counters, indexed by the fetch PC XORed with a speculative global history register (GHR).
- Predicts NR_LANES instruction slots per fetch. Each prediction carries metadata (table index, GHR snapshot) so that execute-stage updates hit the same entry and history can be repaired after a mispredict.

Parameters:
- VLEN, 64, virtual address width.
- NR_ENTRIES, 1024, total counters; power of two, >= NR_LANES.
- NR_LANES, 4, instruction slots per fetch block; power of two.
- LANE_OFFSET, 1, PC LSBs ignored (1 when RVC is enabled, 2 otherwise).
- CTR_BITS, 2, saturating counter width, 2..4.
- GHR_BITS, 8, global history length; must be <= ROW_BITS.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_bp_i  in  1  invalidate all predictor state
- debug_mode_i  in  1  core in debug mode; suppresses training and history pushes
- vpc_i  in  VLEN  fetch-block PC
- bp_valid_o  out  NR_LANES  per-lane entry valid
- bp_taken_o  out  NR_LANES  per-lane predicted taken
- bp_index_o  out  ROW_BITS  row index used; carried as metadata
- bp_ghr_o  out  GHR_BITS  GHR value used; carried as metadata
- spec_push_i  in  1  frontend resolved a conditional branch in the fetch block
- spec_taken_i  in  1  predicted direction of the pushed branch
- upd_valid_i  in  1  branch resolved in execute
- upd_pc_i  in  VLEN  resolved branch PC (lane select)
- upd_index_i  in  ROW_BITS  metadata row index
- upd_ghr_i  in  GHR_BITS  metadata GHR snapshot
- upd_taken_i  in  1  actual outcome
- upd_mispredict_i  in  1  direction was mispredicted

Behaviour:
- Constants:
  - ROW_BITS = log2(NR_ENTRIES/NR_LANES)
  - LANE_BITS = log2(NR_LANES), with 0-width handled as lane 0
  - WEAK_T = 1<<(CTR_BITS-1)
  - CTR_MAX = 2^CTR_BITS-1
- Prediction is combinational and has zero latency:
  - row = vpc_i[ROW_BITS+LANE_BITS+LANE_OFFSET-1 : LANE_BITS+LANE_OFFSET] XOR zero-extended GHR.
  - bp_taken_o[i] = MSB of counter[row][i].
  - bp_valid_o[i] = valid[row][i].
  - bp_index_o = row; bp_ghr_o = current GHR.
- Training applies when upd_valid_i && !debug_mode_i.
  - The lane is upd_pc_i[LANE_BITS+LANE_OFFSET-1:LANE_OFFSET].
  - Entry [upd_index_i][lane] is set valid.
  - Counter increments if taken, decrements if not, saturating at CTR_MAX and 0.
  - The write is registered and visible to predictions the next cycle.
- GHR next-state, in priority order:
  1. flush_bp_i → 0.
  2. upd_valid_i && upd_mispredict_i (debug mode does not block repair) → {upd_ghr_i[GHR_BITS-2:0], upd_taken_i}.
  3. spec_push_i && !debug_mode_i → {GHR[GHR_BITS-2:0], spec_taken_i}.
  4. Otherwise hold.
- A push arriving in the same cycle as a mispredict repair is dropped; the frontend is being redirected.
- flush_bp_i:
  - All valid bits clear, all counters set to WEAK_T, GHR cleared, all in one cycle.
  - A simultaneous update is discarded.
- Reset: all counters 0, valid 0, GHR 0.
  - Outputs after reset: bp_valid_o=0, bp_taken_o=0, bp_ghr_o=0, bp_index_o = PC bits.
- Reset asserted mid-operation clears state asynchronously; any in-flight update is lost.
- Update and predict on the same row in the same cycle: prediction shows the old value (no bypass).
- All index arithmetic wraps modulo 2^ROW_BITS.

Decomposition:
- Shared package: the GHR-shift and saturating-update functions, plus the bp metadata struct {index, ghr} so frontend and execute pipelines can carry it.
- One sub-module: gshare_ctr_bank.
  - One instance per lane.
  - Contains the NR_ROWS x (1+CTR_BITS) register array.
  - Provides one combinational read port, one write port, and a flush input.
  - The top level holds the GHR, index hashing and lane decode.

Test Plan:
1. Reset, vpc_i=0x80000000 → bp_valid_o=0, bp_taken_o=0, bp_ghr_o=0.
2. CTR_BITS=2, update the same index/lane with taken 4 times → counter sequence 0,1,2,3,3; taken prediction from the 2nd update onward. Then 4 not-taken updates → 2,1,0,0.
3. spec_push_i with taken pattern 1,0,1 from GHR=0 → bp_ghr_o=0b101. bp_index_o = PC bits XOR 0x05.
4. GHR=0xFF, mispredict update with upd_ghr_i=0x12, upd_taken_i=0, and spec_push_i in the same cycle → GHR=0x24 next cycle.
5. Train an entry to 3, then pulse flush_bp_i concurrently with an update → all bp_valid_o=0, counter=2 (weakly taken), GHR=0.
6. debug_mode_i=1 with update and push → counters and GHR unchanged. The same cycle with upd_mispredict_i=1 → GHR repaired.

Source files
------------

// File: rtl/gshare_bht_pkg.sv
// gshare_bht_pkg -- shared types and helpers for the gshare direction predictor.
//   bp_meta_t  : prediction metadata {index, ghr} carried from fetch to execute
//                (sized for the default configuration).
//   sat_update : saturating up/down step for counters of up to 4 bits.
//   ghr_shift  : shifts one outcome into a history of up to 32 bits.
package gshare_bht_pkg;

    localparam int unsigned DEF_NR_ENTRIES = 1024;
    localparam int unsigned DEF_NR_LANES   = 4;
    localparam int unsigned DEF_GHR_BITS   = 8;
    localparam int unsigned DEF_ROW_BITS   = $clog2(DEF_NR_ENTRIES / DEF_NR_LANES);

    typedef struct packed {
        logic [DEF_ROW_BITS-1:0] index;
        logic [DEF_GHR_BITS-1:0] ghr;
    } bp_meta_t;

    // Counters travel through this helper zero-extended to 4 bits; the
    // ceiling is derived from the real width so 2..4 bit counters all work.
    function automatic logic [3:0] sat_update(input logic [3:0]  ctr,
                                              input logic        taken,
                                              input int unsigned ctr_bits);
        logic [4:0] max_w;
        logic [3:0] max_v;
        max_w = (5'd1 << ctr_bits) - 5'd1;
        max_v = max_w[3:0];
        if (taken) begin
            return (ctr == max_v) ? ctr : ctr + 4'd1;
        end
        return (ctr == 4'd0) ? ctr : ctr - 4'd1;
    endfunction

    // Youngest outcome enters at bit 0; bits at or above ghr_bits are masked.
    function automatic logic [31:0] ghr_shift(input logic [31:0] ghr,
                                              input logic        taken,
                                              input int unsigned ghr_bits);
        logic [32:0] mask;
        mask = (33'd1 << ghr_bits) - 33'd1;
        return {ghr[30:0], taken} & mask[31:0];
    endfunction

endpackage

// File: rtl/gshare_ctr_bank.sv
// gshare_ctr_bank -- one lane of the gshare pattern table.
//   clk_i, rst_ni : clock, async active-low reset (counters 0, valid 0)
//   flush_i       : clear all valid bits, set all counters to weakly taken
//   rd_row_i      : combinational read row -> rd_valid_o / rd_ctr_o
//   wr_en_i, wr_row_i, wr_taken_i : train one row (set valid, saturating step)
module gshare_ctr_bank
    import gshare_bht_pkg::*;
#(
    parameter int unsigned NR_ROWS  = 256,
    parameter int unsigned ROW_BITS = 8,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [ROW_BITS-1:0] rd_row_i,
    output logic                rd_valid_o,
    output logic [CTR_BITS-1:0] rd_ctr_o,
    input  logic                wr_en_i,
    input  logic [ROW_BITS-1:0] wr_row_i,
    input  logic                wr_taken_i
);

    localparam logic [CTR_BITS-1:0] WEAK_T = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [NR_ROWS-1:0]  valid_q;
    logic [CTR_BITS-1:0] ctr_q [NR_ROWS];
    logic [CTR_BITS-1:0] ctr_next;

    // No bypass: a same-cycle write is only visible after the clock edge.
    assign rd_valid_o = valid_q[rd_row_i];
    assign rd_ctr_o   = ctr_q[rd_row_i];

    assign ctr_next = CTR_BITS'(sat_update(4'(ctr_q[wr_row_i]), wr_taken_i, CTR_BITS));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int r = 0; r < NR_ROWS; r++) begin
                ctr_q[r] <= '0;
            end
        end else if (flush_i) begin
            // Flush wins over a concurrent write.
            valid_q <= '0;
            for (int r = 0; r < NR_ROWS; r++) begin
                ctr_q[r] <= WEAK_T;
            end
        end else if (wr_en_i) begin
            valid_q[wr_row_i] <= 1'b1;
            ctr_q[wr_row_i]   <= ctr_next;
        end
    end

endmodule

// File: rtl/gshare_bht.sv
// gshare_bht -- gshare conditional-branch direction predictor.
//   clk_i, rst_ni      : clock, async active-low reset
//   flush_bp_i         : clear table (weakly taken, invalid) and history
//   debug_mode_i       : blocks training and speculative pushes (not repair)
//   vpc_i              : fetch-block PC; predictions are combinational
//   bp_valid_o/taken_o : per-lane entry valid / predicted direction
//   bp_index_o/ghr_o   : metadata returned later with the update
//   spec_push_i/taken_i: speculative history push from the frontend
//   upd_*              : execute-stage resolution (train + history repair)
module gshare_bht
    import gshare_bht_pkg::*;
#(
    parameter int unsigned VLEN        = 64,
    parameter int unsigned NR_ENTRIES  = 1024,
    parameter int unsigned NR_LANES    = 4,
    parameter int unsigned LANE_OFFSET = 1,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned GHR_BITS    = 8,
    localparam int unsigned NR_ROWS    = NR_ENTRIES / NR_LANES,
    localparam int unsigned ROW_BITS   = $clog2(NR_ROWS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_bp_i,
    input  logic                debug_mode_i,
    input  logic [VLEN-1:0]     vpc_i,
    output logic [NR_LANES-1:0] bp_valid_o,
    output logic [NR_LANES-1:0] bp_taken_o,
    output logic [ROW_BITS-1:0] bp_index_o,
    output logic [GHR_BITS-1:0] bp_ghr_o,
    input  logic                spec_push_i,
    input  logic                spec_taken_i,
    input  logic                upd_valid_i,
    input  logic [VLEN-1:0]     upd_pc_i,
    input  logic [ROW_BITS-1:0] upd_index_i,
    input  logic [GHR_BITS-1:0] upd_ghr_i,
    input  logic                upd_taken_i,
    input  logic                upd_mispredict_i
);

    localparam int unsigned LANE_BITS = $clog2(NR_LANES);
    localparam int unsigned LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int unsigned PC_LO     = LANE_BITS + LANE_OFFSET;

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [ROW_BITS-1:0] rd_row;
    logic [LANE_W-1:0]   upd_lane;
    logic                train;

    // Index hash: PC row bits XOR zero-extended history, wrapping naturally.
    assign rd_row     = vpc_i[PC_LO +: ROW_BITS] ^ ROW_BITS'(ghr_q);
    assign bp_index_o = rd_row;
    assign bp_ghr_o   = ghr_q;

    generate
        if (LANE_BITS > 0) begin : g_lane_sel
            assign upd_lane = upd_pc_i[LANE_OFFSET +: LANE_W];
        end else begin : g_lane_zero
            assign upd_lane = '0;
        end
    endgenerate

    assign train = upd_valid_i && !debug_mode_i && !flush_bp_i;

    for (genvar i = 0; i < NR_LANES; i++) begin : g_lane
        logic [CTR_BITS-1:0] ctr;

        gshare_ctr_bank #(
            .NR_ROWS  (NR_ROWS),
            .ROW_BITS (ROW_BITS),
            .CTR_BITS (CTR_BITS)
        ) i_bank (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .flush_i    (flush_bp_i),
            .rd_row_i   (rd_row),
            .rd_valid_o (bp_valid_o[i]),
            .rd_ctr_o   (ctr),
            .wr_en_i    (train && (upd_lane == LANE_W'(i))),
            .wr_row_i   (upd_index_i),
            .wr_taken_i (upd_taken_i)
        );

        assign bp_taken_o[i] = ctr[CTR_BITS-1];
    end

    // Repair outranks a speculative push: the frontend is being redirected,
    // so any push in that cycle belongs to the wrong path.
    always_comb begin
        ghr_d = ghr_q;
        if (flush_bp_i) begin
            ghr_d = '0;
        end else if (upd_valid_i && upd_mispredict_i) begin
            ghr_d = GHR_BITS'(ghr_shift(32'(upd_ghr_i), upd_taken_i, GHR_BITS));
        end else if (spec_push_i && !debug_mode_i) begin
            ghr_d = GHR_BITS'(ghr_shift(32'(ghr_q), spec_taken_i, GHR_BITS));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{vpc_i, upd_pc_i};

endmodule

// File: tb/tb_gshare_bht.sv
module tb_gshare_bht;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_bp_i;
    logic        debug_mode_i;
    logic [63:0] vpc_i;
    logic [3:0]  bp_valid_o;
    logic [3:0]  bp_taken_o;
    logic [7:0]  bp_index_o;
    logic [7:0]  bp_ghr_o;
    logic        spec_push_i;
    logic        spec_taken_i;
    logic        upd_valid_i;
    logic [63:0] upd_pc_i;
    logic [7:0]  upd_index_i;
    logic [7:0]  upd_ghr_i;
    logic        upd_taken_i;
    logic        upd_mispredict_i;

    int n_tests = 0;
    int n_fail  = 0;

    gshare_bht dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_bp_i       (flush_bp_i),
        .debug_mode_i     (debug_mode_i),
        .vpc_i            (vpc_i),
        .bp_valid_o       (bp_valid_o),
        .bp_taken_o       (bp_taken_o),
        .bp_index_o       (bp_index_o),
        .bp_ghr_o         (bp_ghr_o),
        .spec_push_i      (spec_push_i),
        .spec_taken_i     (spec_taken_i),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_index_i      (upd_index_i),
        .upd_ghr_i        (upd_ghr_i),
        .upd_taken_i      (upd_taken_i),
        .upd_mispredict_i (upd_mispredict_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [7:0] exp_msb;
        exp_msb = 8'b0001_1110;

        rst_ni = 1'b0; flush_bp_i = 1'b0; debug_mode_i = 1'b0;
        vpc_i = 64'h8000_0000; spec_push_i = 1'b0; spec_taken_i = 1'b0;
        upd_valid_i = 1'b0; upd_pc_i = '0; upd_index_i = '0; upd_ghr_i = '0;
        upd_taken_i = 1'b0; upd_mispredict_i = 1'b0;
        #1;

        // 1: reset state
        check("rst_valid", 32'(bp_valid_o), 32'h0);
        check("rst_taken", 32'(bp_taken_o), 32'h0);
        check("rst_ghr",   32'(bp_ghr_o),   32'h0);
        check("rst_index", 32'(bp_index_o), 32'h0);
        step(); step();
        rst_ni = 1'b1;
        step();

        // 2: saturating counter on row 0x10 lane 1 (pc[2:1]=1)
        vpc_i = 64'h80; upd_valid_i = 1'b1; upd_index_i = 8'h10; upd_pc_i = 64'h2;
        upd_taken_i = 1'b1;
        #1;
        check("nobypass_valid", 32'(bp_valid_o), 32'h0);
        for (int k = 0; k < 8; k++) begin
            upd_taken_i = (k < 4);
            step();
            check("train_taken", 32'(bp_taken_o), 32'({2'b00, exp_msb[k], 1'b0}));
        end
        check("train_valid", 32'(bp_valid_o), 32'h2);
        upd_valid_i = 1'b0;

        // 3: speculative pushes 1,0,1
        spec_push_i = 1'b1;
        spec_taken_i = 1'b1; step();
        spec_taken_i = 1'b0; step();
        spec_taken_i = 1'b1; step();
        spec_push_i = 1'b0;
        #1;
        check("push_ghr",   32'(bp_ghr_o),   32'h05);
        check("push_index", 32'(bp_index_o), 32'h15);
        check("push_valid", 32'(bp_valid_o), 32'h0);

        // 4: fill GHR, then repair with a concurrent push
        spec_push_i = 1'b1; spec_taken_i = 1'b1;
        for (int k = 0; k < 8; k++) step();
        check("ghr_full", 32'(bp_ghr_o), 32'hFF);
        upd_valid_i = 1'b1; upd_mispredict_i = 1'b1; upd_ghr_i = 8'h12;
        upd_taken_i = 1'b0; upd_index_i = 8'h40; upd_pc_i = 64'h0;
        step();
        upd_valid_i = 1'b0; upd_mispredict_i = 1'b0; spec_push_i = 1'b0;
        check("repair_ghr", 32'(bp_ghr_o), 32'h24);
        vpc_i = 64'h320;
        #1;
        check("repair_index", 32'(bp_index_o), 32'h40);
        check("repair_valid", 32'(bp_valid_o), 32'h1);
        check("repair_taken", 32'(bp_taken_o), 32'h0);

        // 5: train row 0x30 lane 3 to 3, then flush with a concurrent update
        upd_valid_i = 1'b1; upd_index_i = 8'h30; upd_pc_i = 64'h6; upd_taken_i = 1'b1;
        step(); step(); step();
        upd_valid_i = 1'b0; vpc_i = 64'hA0;
        #1;
        check("pre_flush_taken", 32'(bp_taken_o), 32'h8);
        check("pre_flush_valid", 32'(bp_valid_o), 32'h8);
        flush_bp_i = 1'b1; upd_valid_i = 1'b1; upd_taken_i = 1'b0;
        upd_mispredict_i = 1'b1; upd_ghr_i = 8'h33;
        step();
        flush_bp_i = 1'b0; upd_valid_i = 1'b0; upd_mispredict_i = 1'b0;
        vpc_i = 64'h180;
        #1;
        check("flush_ghr",   32'(bp_ghr_o),   32'h0);
        check("flush_valid", 32'(bp_valid_o), 32'h0);
        check("flush_taken", 32'(bp_taken_o), 32'hF);
        check("flush_index", 32'(bp_index_o), 32'h30);
        upd_valid_i = 1'b1;
        step();
        upd_valid_i = 1'b0;
        check("weak_dec_taken", 32'(bp_taken_o), 32'h7);
        check("weak_dec_valid", 32'(bp_valid_o), 32'h8);

        // 6: debug mode blocks training and pushes but not repair
        debug_mode_i = 1'b1; upd_valid_i = 1'b1; upd_taken_i = 1'b1;
        spec_push_i = 1'b1; spec_taken_i = 1'b1;
        step();
        upd_valid_i = 1'b0; spec_push_i = 1'b0;
        check("dbg_ghr",   32'(bp_ghr_o),   32'h0);
        check("dbg_taken", 32'(bp_taken_o), 32'h7);
        upd_valid_i = 1'b1; upd_mispredict_i = 1'b1; upd_ghr_i = 8'h81;
        spec_push_i = 1'b1;
        step();
        upd_valid_i = 1'b0; upd_mispredict_i = 1'b0; spec_push_i = 1'b0;
        debug_mode_i = 1'b0;
        check("dbg_repair_ghr", 32'(bp_ghr_o), 32'h03);
        vpc_i = 64'h198;
        #1;
        check("dbg_repair_index", 32'(bp_index_o), 32'h30);
        check("dbg_repair_taken", 32'(bp_taken_o), 32'h7);

        // 7: asynchronous reset mid-cycle drops the in-flight update
        upd_valid_i = 1'b1; upd_taken_i = 1'b1; spec_push_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 32'(bp_valid_o), 32'h0);
        check("arst_taken", 32'(bp_taken_o), 32'h0);
        check("arst_ghr",   32'(bp_ghr_o),   32'h0);
        check("arst_index", 32'(bp_index_o), 32'h33);
        upd_valid_i = 1'b0; spec_push_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
